pattern_core: RTL and testbench

- Sequential core that drives the four pattern outputs O_0..O_3 of the TinyTapeout top-level shell; the shell instantiates it directly.
- Takes the pad clock and reset, plus the spare io_in[7:2] pins as control inputs: MODE, SPEED, HOLD.
- Produces a 4-bit LED-style pattern stepped at a programmable rate, plus a step strobe on a spare output.

---
 rtl/pattern_core_if.sv | 15 +
 rtl/pattern_core.sv | 137 +++++++++++++
 tb/tb_pattern_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_core_if.sv
// Pin-level bundle between the TinyTapeout shell and pattern_core:
// synchronised-later control inputs in, registered pattern and step strobe out.
interface pattern_core_if;
  logic [1:0] MODE;
  logic [2:0] SPEED;
  logic       HOLD;
  logic       O_0;
  logic       O_1;
  logic       O_2;
  logic       O_3;
  logic       TICK;

  modport master (output MODE, SPEED, HOLD, input O_0, O_1, O_2, O_3, TICK);
  modport slave  (input MODE, SPEED, HOLD, output O_0, O_1, O_2, O_3, TICK);
endinterface

// File: rtl/pattern_core.sv
// LED-style 4-bit pattern generator (count, shift, bounce, gray) stepped by a
// power-of-two prescaler, with synchronised MODE/SPEED/HOLD controls.
module pattern_core #(
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  pattern_core_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [5:0]       sync_q [SYNC_STAGES];
  logic [5:0]       sync_d [SYNC_STAGES];
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] term;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cnt_inc;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_s;
  logic [2:0]       speed_s;
  logic             hold_s;
  logic             step;

  // Control pins are packed {HOLD, SPEED, MODE} and moved through the chain together.
  always_comb begin
    sync_d[0] = {bus.HOLD, bus.SPEED, bus.MODE};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign hold_s  = sync_q[SYNC_STAGES-1][5];
  assign speed_s = sync_q[SYNC_STAGES-1][4:2];
  assign mode_s  = mode_e'(sync_q[SYNC_STAGES-1][1:0]);

  // Using >= lets a lowered SPEED fire on the next cycle instead of wrapping DIV.
  always_comb begin
    term  = (DIV_W'(1) << speed_s) - DIV_W'(1);
    step  = 1'b0;
    div_d = div_q;
    if (!hold_s) begin
      step  = (div_q >= term);
      div_d = step ? '0 : div_q + DIV_W'(1);
    end
  end

  always_comb begin
    cnt_inc = cnt_q + 4'd1;
    pat_d   = pat_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tick_d  = step;
    if (step) begin
      if (mode_s != mode_q) begin
        mode_d = mode_s;
        case (mode_s)
          MODE_COUNT:  pat_d = 4'b0000;
          MODE_SHIFT:  pat_d = 4'b0001;
          MODE_BOUNCE: begin
            pat_d = 4'b0001;
            dir_d = DIR_LEFT;
          end
          MODE_GRAY: begin
            pat_d = 4'b0000;
            cnt_d = 4'b0000;
          end
          default: pat_d = 4'b0000;
        endcase
      end else begin
        case (mode_q)
          MODE_COUNT: pat_d = pat_q + 4'd1;
          MODE_SHIFT: pat_d = $onehot(pat_q) ? {pat_q[2:0], pat_q[3]} : 4'b0001;
          MODE_BOUNCE: begin
            if (!$onehot(pat_q)) begin
              pat_d = 4'b0001;
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT) begin
              pat_d = pat_q << 1;
              if (pat_d == 4'b1000) dir_d = DIR_RIGHT;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_d == 4'b0001) dir_d = DIR_LEFT;
            end
          end
          MODE_GRAY: begin
            cnt_d = cnt_inc;
            pat_d = cnt_inc ^ (cnt_inc >> 1);
          end
          default: pat_d = 4'b0000;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      div_q  <= '0;
      pat_q  <= 4'b0000;
      cnt_q  <= 4'b0000;
      dir_q  <= DIR_LEFT;
      tick_q <= 1'b0;
      mode_q <= MODE_COUNT;
    end else begin
      sync_q <= sync_d;
      div_q  <= div_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
    end
  end

  assign bus.O_0  = pat_q[0];
  assign bus.O_1  = pat_q[1];
  assign bus.O_2  = pat_q[2];
  assign bus.O_3  = pat_q[3];
  assign bus.TICK = tick_q;

endmodule

// File: tb/tb_pattern_core.sv
// Randomised and directed bench for pattern_core against a step-index reference
// model: each mode's pattern is a function of how many steps since its seed.
module tb_pattern_core;

  localparam int DIV_W       = 8;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] dut_pat;

  pattern_core_if bus ();

  pattern_core #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign dut_pat = {bus.O_3, bus.O_2, bus.O_1, bus.O_0};

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: control-pin pipeline, cycles since last step, mode and step index.
  logic [5:0] m_pipe [$];
  int         m_elapsed;
  logic [1:0] m_mode;
  int         m_k;
  logic [3:0] m_pat;
  logic       m_tick;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] pattern_of(input logic [1:0] mode, input int k);
    int g;
    g = k % 16;
    case (mode)
      2'd0: return 4'(g);
      2'd1: return 4'(1 << (k % 4));
      2'd2: begin
        case (k % 6)
          0: return 4'b0001;
          1: return 4'b0010;
          2: return 4'b0100;
          3: return 4'b1000;
          4: return 4'b0100;
          default: return 4'b0010;
        endcase
      end
      default: return 4'(g ^ (g >> 1));
    endcase
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(6'd0);
    m_elapsed = 0;
    m_mode    = 2'd0;
    m_k       = 0;
    m_pat     = 4'b0000;
    m_tick    = 1'b0;
  endtask

  task automatic model_edge();
    logic [5:0] synced;
    logic       step;
    synced = m_pipe[0];
    step   = 1'b0;
    if (!synced[5]) begin
      if (m_elapsed >= (1 << synced[4:2]) - 1) begin
        step      = 1'b1;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end
    if (step) begin
      if (synced[1:0] != m_mode) begin
        m_mode = synced[1:0];
        m_k    = 0;
      end else begin
        m_k = (m_k + 1) % 48;
      end
      m_pat = pattern_of(m_mode, m_k);
    end
    m_tick = step;
    void'(m_pipe.pop_front());
    m_pipe.push_back({bus.HOLD, bus.SPEED, bus.MODE});
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("pat", dut_pat, m_pat);
    checkOutput("tick", 4'(bus.TICK), 4'(m_tick));
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [2:0] speed, input logic hold, input int cycles);
    bus.MODE  = mode;
    bus.SPEED = speed;
    bus.HOLD  = hold;
    for (int i = 0; i < cycles; i++) run_cycle();
  endtask

  // Reset lands between edges so the outputs must clear without a clock.
  task automatic async_reset(input logic [1:0] mode, input logic [2:0] speed);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pat", dut_pat, 4'b0000);
    checkOutput("async_rst_tick", 4'(bus.TICK), 4'b0);
    model_reset();
    bus.MODE  = mode;
    bus.SPEED = speed;
    bus.HOLD  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] bounce_exp [8];
    logic [3:0] prev;
    bit         seen;

    bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rst       = 1'b1;
    bus.MODE  = 2'd0;
    bus.SPEED = 3'd0;
    bus.HOLD  = 1'b0;
    model_reset();
    #12;
    checkOutput("reset_pat", dut_pat, 4'b0000);
    checkOutput("reset_tick", 4'(bus.TICK), 4'b0);
    @(negedge clk);
    rst = 1'b0;

    run_cycle();
    checkOutput("count_first", dut_pat, 4'b0001);
    applyStimulus(2'd0, 3'd0, 1'b0, 20);
    applyStimulus(2'd0, 3'd3, 1'b0, 40);
    applyStimulus(2'd0, 3'd5, 1'b0, 12);
    applyStimulus(2'd0, 3'd0, 1'b0, 6);

    applyStimulus(2'd2, 3'd0, 1'b0, SYNC_STAGES + 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) run_cycle();
      checkOutput("bounce_seq", dut_pat, bounce_exp[i]);
    end

    applyStimulus(2'd3, 3'd0, 1'b0, SYNC_STAGES + 1);
    checkOutput("gray_seed", dut_pat, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      prev = dut_pat;
      run_cycle();
      checkOutput("gray_adjacent", 4'($countones(prev ^ dut_pat)), 4'd1);
    end

    applyStimulus(2'd3, 3'd0, 1'b1, 8);
    applyStimulus(2'd1, 3'd0, 1'b1, 12);
    bus.HOLD = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_cycle();
      if (bus.TICK) begin
        seen = 1'b1;
        checkOutput("hold_release_seed", dut_pat, 4'b0001);
      end
    end
    checkOutput("hold_release_tick_seen", 4'(seen), 4'b1);

    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_cycle();
      if (m_pat == 4'b0100) seen = 1'b1;
    end
    checkOutput("shift_reach_0100", 4'(seen), 4'b1);
    async_reset(2'd0, 3'd0);
    run_cycle();
    checkOutput("rst_first_step", dut_pat, 4'b0001);

    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 14) == 0) begin
        async_reset(2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      end
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0), $urandom_range(1, 30));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
